conv_operand_packer: RTL and testbench
======================================

# conv_operand_packer

Serial-to-parallel operand feeder for the 32-lane convolution datapath. Accepts one 4-bit operand per cycle on a valid/ready stream, tagged as weight or IFM, assembles 32-lane vectors, and emits each completed vector as a single-cycle `weight_valid` or `in_valid` pulse with the packed bus held stable. Sits between the host/loader stream and the convolution core's parallel `In_Weight_*` / `In_IFM_*` inputs.

## Interface
- `LANES`, default 32: lanes per vector.
- `DW`, default 4: bits per operand.
- `CW`, default 16: width of the vector counters.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  input beat ready.
- `s_data`  in  DW  operand value.
- `s_kind`  in  1  0 = IFM operand, 1 = weight operand.
- `flush`  in  1  discard partial vector and the weight-loaded flag.
- `weight_valid`  out  1  one-cycle pulse: `weight_bus` holds a new weight vector.
- `weight_bus`  out  LANES*DW  lane i at bits [DW*i+DW-1 : DW*i]; lane 0 drives `In_Weight_1`.
- `in_valid`  out  1  one-cycle pulse: `ifm_bus` holds a new IFM vector.
- `ifm_bus`  out  LANES*DW  same packing; lane 0 drives `In_IFM_1`.
- `err_kind`  out  1  one-cycle pulse: kind changed mid-vector.
- `err_noweight`  out  1  one-cycle pulse: IFM vector completed with no weights loaded, dropped.
- `ifm_count`  out  CW  IFM vectors emitted since reset/flush, wraps.

## Operation
- Beat accepted when `s_valid && s_ready`. `s_ready` = !`flush`.
- Assembly buffer (LANES*DW) plus lane counter (0..LANES-1) and latched kind `cur_kind`. The first beat of a vector goes to lane 0 and sets `cur_kind`; each accepted beat goes to lane = counter, then the counter increments.
- FSM over weight status: `NO_W` (reset) → `W_OK` on first completed weight vector. `flush` returns to `NO_W`. No other transitions.
- On an accepted beat at lane LANES-1:
  - Weight kind: copy the full vector into `weight_bus` and pulse `weight_valid`. Valid in both states, so reload is allowed any time.
  - IFM kind in `W_OK`: copy into `ifm_bus`, pulse `in_valid`, and increment `ifm_count`.
  - IFM kind in `NO_W`: do not update `ifm_bus`, pulse `err_noweight` instead of `in_valid`, and leave `ifm_count` unchanged.
  - In every case the lane counter returns to 0.
- Kind mismatch (lane counter ≠ 0 and `s_kind` ≠ `cur_kind`):
  - Discard the partial vector and pulse `err_kind`.
  - The offending beat is accepted as lane 0 of a new vector of the new kind; the counter becomes 1.
- `flush`:
  - Clears the lane counter, state → `NO_W`, `ifm_count` → 0.
  - `weight_bus` and `ifm_bus` keep their contents.
  - Any beat presented during flush is not accepted.
- Buses change only on their own valid pulse and hold between pulses.
- Unused assembly lanes never leak: a vector is emitted only when all LANES beats have arrived since the last lane-0 beat.
- Arithmetic: counter increments are modulo 2^CW. Lane counter width is clog2(LANES).

## Timing
- Reset (`rst_n` low at a rising edge):
  - `weight_valid`, `in_valid`, `err_kind`, `err_noweight` = 0.
  - `weight_bus`, `ifm_bus`, `ifm_count` = 0.
  - State `NO_W`, lane counter 0, `cur_kind` 0.
  - `s_ready` = 1 once `flush` is low.
- Reset mid-vector discards the partial vector. It has priority over `flush` and beats.
- Latency: last beat accepted on edge t → valid pulse and updated bus visible after edge t, i.e. for the cycle following t. Exactly one cycle wide.
- Throughput: one vector per LANES accepted beats. Back-to-back vectors give valid pulses LANES cycles apart.
- Because weight and IFM pulses come from different vectors, they never coincide.
- `err_kind` is registered: it is asserted the cycle after the offending beat.
- `flush` and a completing beat in the same cycle: flush wins, no pulse.

## Structure
- Shared package `conv_pkg`:
  - `CONV_LANES` = 32, `CONV_DW` = 4, `CONV_OFM_W` = 13.
  - Kind encoding constants `KIND_IFM` = 0, `KIND_W` = 1.
  - State enum {`NO_W`, `W_OK`}.
- One natural sub-module, `lane_assembler`: buffer, lane counter, kind latch, mismatch detect, and a "complete" strobe with vector output. The top holds the FSM, output registers and counters.

## Test plan
- Reset, then 32 weight beats with values 1..15,0,1..15,0 → one `weight_valid` pulse the cycle after beat 32. `weight_bus`[3:0]=1, [63:60]=0. State `W_OK`.
- From `W_OK`, 32 IFM beats all = 0xF, then 32 beats i%16 → two `in_valid` pulses 32 cycles apart. `ifm_bus` = all-F, then the lane pattern. `ifm_count` = 2.
- After reset, 32 IFM beats → `err_noweight` pulse, no `in_valid`. `ifm_bus` stays 0, `ifm_count` stays 0.
- In `W_OK`, 10 IFM beats then 32 weight beats → `err_kind` the cycle after beat 11. One `weight_valid` after the 32nd weight beat. No `in_valid`.
- 20 IFM beats, then `flush` asserted together with a valid beat → `s_ready` = 0, beat dropped. State `NO_W`, `ifm_count` = 0. A subsequent 32-IFM vector → `err_noweight`.
- `rst_n` low at beat 16 of a weight vector, then 32 weight beats → exactly one `weight_valid`, bus equal to the new 32 beats only.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, operand kind encoding and weight-status state for the convolution feeder.
package conv_pkg;
   localparam int CONV_LANES = 32;
   localparam int CONV_DW    = 4;
   localparam int CONV_OFM_W = 13;
   localparam logic KIND_IFM = 1'b0;
   localparam logic KIND_W   = 1'b1;
   typedef enum logic {NO_W, W_OK} w_state_e;
endpackage

// File: rtl/lane_assembler.sv
// lane_assembler: collects DW-bit beats into a LANES-wide vector, flags completion and kind mismatch.
module lane_assembler import conv_pkg::*; #(
   parameter int LANES = CONV_LANES,
   parameter int DW    = CONV_DW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                beat,
   input  logic                kind,
   input  logic [DW-1:0]       data,
   output logic                complete,
   output logic                mismatch,
   output logic [LANES*DW-1:0] vec
);
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   logic [LW-1:0]       lane_q, lane_d, lane;
   logic                kind_q, kind_d;
   logic [LANES*DW-1:0] asm_q, asm_d;
   // A mismatching beat restarts the vector at lane 0, so vec always reflects the beat's real lane.
   always_comb begin
      mismatch = beat && lane_q != '0 && kind != kind_q;
      lane = mismatch ? '0 : lane_q;
      vec = asm_q;
      vec[lane*DW +: DW] = data;
      complete = beat && lane == LW'(LANES-1);
      kind_d = (beat && lane == '0) ? kind : kind_q;
      asm_d = beat ? vec : asm_q;
      lane_d = flush ? '0 : !beat ? lane_q : complete ? '0 : lane + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane_q <= '0;
         kind_q <= KIND_IFM;
         asm_q <= '0;
      end else begin
         lane_q <= lane_d;
         kind_q <= kind_d;
         asm_q <= asm_d;
      end
   end
endmodule

// File: rtl/conv_operand_packer.sv
// conv_operand_packer: serial-to-parallel feeder turning a tagged 4-bit operand stream into
// 32-lane weight/IFM vectors with single-cycle valid pulses for the convolution core.
module conv_operand_packer import conv_pkg::*; #(
   parameter int LANES = CONV_LANES,
   parameter int DW    = CONV_DW,
   parameter int CW    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DW-1:0]       s_data,
   input  logic                s_kind,
   input  logic                flush,
   output logic                weight_valid,
   output logic [LANES*DW-1:0] weight_bus,
   output logic                in_valid,
   output logic [LANES*DW-1:0] ifm_bus,
   output logic                err_kind,
   output logic                err_noweight,
   output logic [CW-1:0]       ifm_count
);
   w_state_e            state_q, state_d;
   logic                accept, complete, mismatch;
   logic [LANES*DW-1:0] vec;
   logic                weight_valid_q, weight_valid_d, in_valid_q, in_valid_d;
   logic                err_kind_q, err_kind_d, err_noweight_q, err_noweight_d;
   logic [LANES*DW-1:0] weight_bus_q, weight_bus_d, ifm_bus_q, ifm_bus_d;
   logic [CW-1:0]       ifm_count_q, ifm_count_d;
   assign s_ready = !flush;
   assign accept = s_valid && s_ready;
   lane_assembler #(.LANES(LANES), .DW(DW)) u_asm (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .beat     (accept),
      .kind     (s_kind),
      .data     (s_data),
      .complete (complete),
      .mismatch (mismatch),
      .vec      (vec)
   );
   // IFM vectors completed before any weights are loaded are dropped and reported instead.
   always_comb begin
      weight_valid_d = complete && s_kind == KIND_W;
      in_valid_d = complete && s_kind == KIND_IFM && state_q == W_OK;
      err_noweight_d = complete && s_kind == KIND_IFM && state_q == NO_W;
      err_kind_d = mismatch;
      weight_bus_d = weight_valid_d ? vec : weight_bus_q;
      ifm_bus_d = in_valid_d ? vec : ifm_bus_q;
      ifm_count_d = flush ? '0 : ifm_count_q + CW'(in_valid_d);
      state_d = flush ? NO_W : weight_valid_d ? W_OK : state_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= NO_W;
         weight_valid_q <= 1'b0;
         in_valid_q <= 1'b0;
         err_kind_q <= 1'b0;
         err_noweight_q <= 1'b0;
         weight_bus_q <= '0;
         ifm_bus_q <= '0;
         ifm_count_q <= '0;
      end else begin
         state_q <= state_d;
         weight_valid_q <= weight_valid_d;
         in_valid_q <= in_valid_d;
         err_kind_q <= err_kind_d;
         err_noweight_q <= err_noweight_d;
         weight_bus_q <= weight_bus_d;
         ifm_bus_q <= ifm_bus_d;
         ifm_count_q <= ifm_count_d;
      end
   end
   assign weight_valid = weight_valid_q;
   assign in_valid = in_valid_q;
   assign err_kind = err_kind_q;
   assign err_noweight = err_noweight_q;
   assign weight_bus = weight_bus_q;
   assign ifm_bus = ifm_bus_q;
   assign ifm_count = ifm_count_q;
endmodule

// File: tb/tb_conv_operand_packer.sv
// tb_conv_operand_packer: directed stimulus with a reference model feeding an event scoreboard.
module tb_conv_operand_packer;
   localparam int LANES = 32, DW = 4, CW = 16, BW = LANES*DW;
   localparam logic [3:0] EV_W = 4'b1000, EV_I = 4'b0100, EV_NW = 4'b0010, EV_K = 4'b0001;
   logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_kind = 1'b0, flush = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic s_ready, weight_valid, in_valid, err_kind, err_noweight;
   logic [BW-1:0] weight_bus, ifm_bus;
   logic [CW-1:0] ifm_count;
   conv_operand_packer #(.LANES(LANES), .DW(DW), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_kind(s_kind), .flush(flush), .weight_valid(weight_valid), .weight_bus(weight_bus),
      .in_valid(in_valid), .ifm_bus(ifm_bus), .err_kind(err_kind), .err_noweight(err_noweight),
      .ifm_count(ifm_count)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0]    ev;
      logic [BW-1:0] w;
      logic [BW-1:0] i;
      logic [CW-1:0] cnt;
      int            due;
   } exp_t;
   exp_t q[$];
   int checks = 0, errors = 0, cyc = 0;
   logic [DW-1:0] mlane [LANES];
   int mcnt = 0;
   logic mkind = 1'b0, mstate = 1'b0;
   logic [BW-1:0] mw = '0, mi = '0;
   logic [CW-1:0] mc = '0;
   task automatic chk(string tag, logic [BW-1:0] obs, logic [BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic push(logic [3:0] ev);
      exp_t e;
      e.ev = ev; e.w = mw; e.i = mi; e.cnt = mc; e.due = cyc + 1;
      q.push_back(e);
   endtask
   // Pulses must arrive exactly on their due cycle with the expected buses and count.
   always @(posedge clk) begin
      exp_t e;
      logic [3:0] pv;
      cyc++;
      #1;
      pv = {weight_valid, in_valid, err_noweight, err_kind};
      if (pv != 4'b0) begin
         if (q.size() == 0) chk("unexpected_pulse", BW'(pv), '0);
         else begin
            e = q.pop_front();
            chk("pulse_cycle", BW'(cyc), BW'(e.due));
            chk("pulse_kind", BW'(pv), BW'(e.ev));
            chk("weight_bus", weight_bus, e.w);
            chk("ifm_bus", ifm_bus, e.i);
            chk("ifm_count", BW'(ifm_count), BW'(e.cnt));
         end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         chk("missed_pulse", BW'(pv), BW'(e.ev));
      end
   end
   task automatic send(logic k, logic [DW-1:0] d);
      logic [BW-1:0] v;
      s_valid = 1'b1; s_kind = k; s_data = d;
      if (mcnt != 0 && k != mkind) begin
         push(EV_K);
         mcnt = 0;
      end
      if (mcnt == 0) mkind = k;
      mlane[mcnt] = d;
      mcnt++;
      if (mcnt == LANES) begin
         mcnt = 0;
         for (int j = 0; j < LANES; j++) v[j*DW +: DW] = mlane[j];
         if (k) begin mw = v; mstate = 1'b1; push(EV_W); end
         else if (mstate) begin mi = v; mc++; push(EV_I); end
         else push(EV_NW);
      end
      @(negedge clk);
   endtask
   task automatic idle(int n);
      s_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask
   task automatic do_reset();
      rst_n = 1'b0; s_valid = 1'b0; flush = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mcnt = 0; mkind = 1'b0; mstate = 1'b0; mw = '0; mi = '0; mc = '0;
   endtask
   task automatic do_flush();
      flush = 1'b1; s_valid = 1'b1; s_kind = 1'b0; s_data = 4'h5;
      #1 chk("s_ready_flush", BW'(s_ready), '0);
      @(negedge clk);
      flush = 1'b0; s_valid = 1'b0;
      mcnt = 0; mstate = 1'b0; mc = '0;
   endtask
   initial begin
      @(negedge clk);
      do_reset();
      chk("rst_weight_valid", BW'(weight_valid), '0);
      chk("rst_in_valid", BW'(in_valid), '0);
      chk("rst_err_kind", BW'(err_kind), '0);
      chk("rst_err_noweight", BW'(err_noweight), '0);
      chk("rst_weight_bus", weight_bus, '0);
      chk("rst_ifm_bus", ifm_bus, '0);
      chk("rst_ifm_count", BW'(ifm_count), '0);
      chk("rst_s_ready", BW'(s_ready), BW'(1));
      for (int i = 0; i < LANES; i++) send(1'b1, DW'((i + 1) % 16));
      idle(2);
      chk("w_lane0", BW'(weight_bus[3:0]), BW'(1));
      chk("w_lane15", BW'(weight_bus[63:60]), '0);
      for (int i = 0; i < LANES; i++) send(1'b0, 4'hF);
      for (int i = 0; i < LANES; i++) send(1'b0, DW'(i % 16));
      idle(2);
      chk("ifm_count_two", BW'(ifm_count), BW'(2));
      chk("ifm_lane5", BW'(ifm_bus[23:20]), BW'(5));
      do_reset();
      for (int i = 0; i < LANES; i++) send(1'b0, DW'(i));
      idle(2);
      chk("noweight_ifm_bus", ifm_bus, '0);
      chk("noweight_count", BW'(ifm_count), '0);
      for (int i = 0; i < LANES; i++) send(1'b1, 4'h3);
      for (int i = 0; i < 10; i++) send(1'b0, DW'(i));
      for (int i = 0; i < LANES; i++) send(1'b1, DW'(i * 7));
      idle(2);
      chk("kind_err_count", BW'(ifm_count), '0);
      for (int i = 0; i < LANES; i++) send(1'b0, DW'(i + 2));
      for (int i = 0; i < 20; i++) send(1'b0, 4'hA);
      do_flush();
      idle(1);
      chk("flush_count", BW'(ifm_count), '0);
      for (int i = 0; i < LANES; i++) send(1'b0, 4'h6);
      idle(2);
      for (int i = 0; i < 16; i++) send(1'b1, 4'h9);
      do_reset();
      for (int i = 0; i < LANES; i++) send(1'b1, DW'(15 - i % 16));
      idle(3);
      chk("w_after_reset_lane0", BW'(weight_bus[3:0]), BW'(15));
      chk("queue_drained", BW'(q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
